// File: rtl/control_sequencer.sv
// control_sequencer: microcoded control unit of the 8-bit computer.
// Walks fetch (T0-T1) and execute (T2-T4) micro-steps, decodes the IR opcode
// together with the latched ALU flags, and emits the 15-bit control word
// {HLT,MI,RI,RO,IO,II,AI,AO,EO,SU,BI,OI,CE,CO,J} every clock.
// Optional feature macro: CTRL_SKIP_EN -- when defined, the step counter
// returns to T0 right after the last useful micro-step of each opcode
// instead of always running NUM_STEPS cycles per instruction.
module control_sequencer #(
    parameter int NUM_STEPS = 5,
    parameter int STEP_W    = 3
) (
    input  logic              clk,
    input  logic              RESETn,
    input  logic [3:0]        opcode,
    input  logic              alu_carry,
    input  logic              alu_zero,
    output logic [14:0]       ctrl,
    output logic [STEP_W-1:0] step,
    output logic              halted
);

    // Control word bit positions
    localparam int B_HLT = 14;
    localparam int B_MI  = 13;
    localparam int B_RI  = 12;
    localparam int B_RO  = 11;
    localparam int B_IO  = 10;
    localparam int B_II  = 9;
    localparam int B_AI  = 8;
    localparam int B_AO  = 7;
    localparam int B_EO  = 6;
    localparam int B_SU  = 5;
    localparam int B_BI  = 4;
    localparam int B_OI  = 3;
    localparam int B_CE  = 2;
    localparam int B_CO  = 1;
    localparam int B_J   = 0;

    localparam logic [STEP_W-1:0] T0   = STEP_W'(0);
    localparam logic [STEP_W-1:0] T1   = STEP_W'(1);
    localparam logic [STEP_W-1:0] T2   = STEP_W'(2);
    localparam logic [STEP_W-1:0] T3   = STEP_W'(3);
    localparam logic [STEP_W-1:0] T4   = STEP_W'(4);
    localparam logic [STEP_W-1:0] TEND = STEP_W'(NUM_STEPS - 1);

    typedef enum logic [3:0] {
        OP_NOP = 4'b0000,
        OP_LDA = 4'b0001,
        OP_ADD = 4'b0010,
        OP_SUB = 4'b0011,
        OP_STA = 4'b0100,
        OP_LDI = 4'b0101,
        OP_JMP = 4'b0110,
        OP_JC  = 4'b0111,
        OP_JZ  = 4'b1000,
        OP_OUT = 4'b1110,
        OP_HLT = 4'b1111
    } opcode_t;

    logic [STEP_W-1:0] step_q;
    logic [STEP_W-1:0] step_next;
    logic              carry_q;
    logic              zero_q;
    logic              halted_q;
    logic              halted_next;
    logic [14:0]       ctrl_word;
    logic              fi;
    logic              instr_done;
    opcode_t           op;

    assign op = opcode_t'(opcode);

`ifdef CTRL_SKIP_EN
    // Last micro-step that does useful work for a given opcode; jumps and
    // single-step opcodes finish at T2 whether or not the jump is taken.
    function automatic logic [STEP_W-1:0] exec_last(input opcode_t o);
        case (o)
            OP_LDA, OP_STA: exec_last = T3;
            OP_ADD, OP_SUB: exec_last = T4;
            default:        exec_last = T2;
        endcase
    endfunction
`endif

    // State register: step counter, latched ALU flags and halt flag
    always_ff @(posedge clk) begin
        if (!RESETn) begin
            step_q   <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            step_q   <= step_next;
            halted_q <= halted_next;
            if (fi) begin
                carry_q <= alu_carry;
                zero_q  <= alu_zero;
            end
        end
    end

    // Micro-instruction decode and next-step selection
    always_comb begin
        ctrl_word   = '0;
        fi          = 1'b0;
        halted_next = halted_q;
        step_next   = step_q;
        instr_done  = 1'b0;

        if (halted_q) begin
            // Frozen in halt: only reset leaves this state
            ctrl_word[B_HLT] = 1'b1;
        end else begin
            case (step_q)
                T0: begin
                    ctrl_word[B_CO] = 1'b1;
                    ctrl_word[B_MI] = 1'b1;
                end
                T1: begin
                    ctrl_word[B_RO] = 1'b1;
                    ctrl_word[B_II] = 1'b1;
                    ctrl_word[B_CE] = 1'b1;
                end
                T2: begin
                    case (op)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                            ctrl_word[B_IO] = 1'b1;
                            ctrl_word[B_MI] = 1'b1;
                        end
                        OP_LDI: begin
                            ctrl_word[B_IO] = 1'b1;
                            ctrl_word[B_AI] = 1'b1;
                        end
                        OP_JMP: begin
                            ctrl_word[B_IO] = 1'b1;
                            ctrl_word[B_J]  = 1'b1;
                        end
                        OP_JC: begin
                            ctrl_word[B_IO] = carry_q;
                            ctrl_word[B_J]  = carry_q;
                        end
                        OP_JZ: begin
                            ctrl_word[B_IO] = zero_q;
                            ctrl_word[B_J]  = zero_q;
                        end
                        OP_OUT: begin
                            ctrl_word[B_AO] = 1'b1;
                            ctrl_word[B_OI] = 1'b1;
                        end
                        OP_HLT: begin
                            ctrl_word[B_HLT] = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T3: begin
                    case (op)
                        OP_LDA: begin
                            ctrl_word[B_RO] = 1'b1;
                            ctrl_word[B_AI] = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            ctrl_word[B_RO] = 1'b1;
                            ctrl_word[B_BI] = 1'b1;
                        end
                        OP_STA: begin
                            ctrl_word[B_AO] = 1'b1;
                            ctrl_word[B_RI] = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T4: begin
                    if (op == OP_ADD || op == OP_SUB) begin
                        ctrl_word[B_EO] = 1'b1;
                        ctrl_word[B_AI] = 1'b1;
                        ctrl_word[B_SU] = (op == OP_SUB);
                        fi              = 1'b1;
                    end
                end
                default: ;
            endcase

`ifdef CTRL_SKIP_EN
            instr_done = (step_q == TEND) ||
                         ((step_q >= T2) && (step_q == exec_last(op)));
`else
            instr_done = (step_q == TEND);
`endif

            if (step_q == T2 && op == OP_HLT) begin
                // Halt takes effect on this edge; step stays parked at T2
                halted_next = 1'b1;
            end else if (instr_done) begin
                step_next = '0;
            end else begin
                step_next = step_q + STEP_W'(1);
            end
        end
    end

    assign ctrl   = RESETn ? ctrl_word : '0;
    assign step   = step_q;
    assign halted = halted_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed-vector bench for control_sequencer with hand-computed control words.
module tb_control_sequencer;

    localparam int STEP_W = 3;

    localparam logic [14:0] C_HLT = 15'h4000;
    localparam logic [14:0] C_MI  = 15'h2000;
    localparam logic [14:0] C_RI  = 15'h1000;
    localparam logic [14:0] C_RO  = 15'h0800;
    localparam logic [14:0] C_IO  = 15'h0400;
    localparam logic [14:0] C_II  = 15'h0200;
    localparam logic [14:0] C_AI  = 15'h0100;
    localparam logic [14:0] C_AO  = 15'h0080;
    localparam logic [14:0] C_EO  = 15'h0040;
    localparam logic [14:0] C_SU  = 15'h0020;
    localparam logic [14:0] C_BI  = 15'h0010;
    localparam logic [14:0] C_OI  = 15'h0008;
    localparam logic [14:0] C_CE  = 15'h0004;
    localparam logic [14:0] C_CO  = 15'h0002;
    localparam logic [14:0] C_J   = 15'h0001;

    localparam logic [14:0] W_T0 = C_CO | C_MI;          // 15'h2002
    localparam logic [14:0] W_T1 = C_RO | C_II | C_CE;   // 15'h0A04

    logic              clk = 1'b0;
    logic              RESETn;
    logic [3:0]        opcode;
    logic              alu_carry;
    logic              alu_zero;
    logic [14:0]       ctrl;
    logic [STEP_W-1:0] step;
    logic              halted;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    control_sequencer #(
        .NUM_STEPS(5),
        .STEP_W   (STEP_W)
    ) dut (
        .clk      (clk),
        .RESETn   (RESETn),
        .opcode   (opcode),
        .alu_carry(alu_carry),
        .alu_zero (alu_zero),
        .ctrl     (ctrl),
        .step     (step),
        .halted   (halted)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Check step/ctrl of the current cycle, then move past the next rising edge
    task automatic cyc(input string tag, input logic [STEP_W-1:0] exp_step,
                       input logic [14:0] exp_ctrl);
        #1;
        chk({tag, "_step"}, 16'(step), 16'(exp_step));
        chk({tag, "_ctrl"}, 16'(ctrl), 16'(exp_ctrl));
        @(posedge clk);
        #1;
    endtask

    // Fetch cycles are identical for every instruction
    task automatic fetch(input string tag, input logic [3:0] op);
        opcode = op;
        cyc({tag, "_t0"}, 3'd0, W_T0);
        cyc({tag, "_t1"}, 3'd1, W_T1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RESETn    = 1'b0;
        opcode    = 4'h0;
        alu_carry = 1'b0;
        alu_zero  = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        #1;
        chk("rst_ctrl", 16'(ctrl), 16'h0000);
        chk("rst_step", 16'(step), 16'h0000);
        chk("rst_halted", 16'(halted), 16'h0000);
        RESETn = 1'b1;

`ifdef CTRL_SKIP_EN
        // LDI, ADD, JMP back to back: T0 recurs after 3, 5, 3 cycles
        fetch("ldi", 4'b0101);
        cyc("ldi_t2", 3'd2, C_IO | C_AI);
        fetch("add", 4'b0010);
        cyc("add_t2", 3'd2, C_IO | C_MI);
        cyc("add_t3", 3'd3, C_RO | C_BI);
        cyc("add_t4", 3'd4, C_EO | C_AI);
        fetch("jmp", 4'b0110);
        cyc("jmp_t2", 3'd2, C_IO | C_J);
        fetch("lda", 4'b0001);
        cyc("lda_t2", 3'd2, C_IO | C_MI);
        cyc("lda_t3", 3'd3, C_RO | C_AI);
        fetch("jc", 4'b0111);
        cyc("jc_t2", 3'd2, 15'h0000);
        fetch("nop", 4'b0000);
        cyc("nop_t2", 3'd2, 15'h0000);
        cyc("next_t0", 3'd0, W_T0);
`else
        // Plain stepping with NOP: 0,1,2,3,4,0
        fetch("nop", 4'b0000);
        cyc("nop_t2", 3'd2, 15'h0000);
        cyc("nop_t3", 3'd3, 15'h0000);
        cyc("nop_t4", 3'd4, 15'h0000);

        // ADD producing carry=1, zero=0
        fetch("add", 4'b0010);
        cyc("add_t2", 3'd2, C_IO | C_MI);
        cyc("add_t3", 3'd3, C_RO | C_BI);
        alu_carry = 1'b1;
        alu_zero  = 1'b0;
        cyc("add_t4", 3'd4, C_EO | C_AI);
        // Live ALU now disagrees with the latched flags
        alu_carry = 1'b0;
        alu_zero  = 1'b1;

        fetch("jc1", 4'b0111);
        cyc("jc_taken", 3'd2, C_IO | C_J);
        cyc("jc1_t3", 3'd3, 15'h0000);
        cyc("jc1_t4", 3'd4, 15'h0000);
        fetch("jz1", 4'b1000);
        cyc("jz_not_taken", 3'd2, 15'h0000);
        cyc("jz1_t3", 3'd3, 15'h0000);
        cyc("jz1_t4", 3'd4, 15'h0000);

        // SUB producing carry=0, zero=1
        fetch("sub", 4'b0011);
        cyc("sub_t2", 3'd2, C_IO | C_MI);
        cyc("sub_t3", 3'd3, C_RO | C_BI);
        alu_carry = 1'b0;
        alu_zero  = 1'b1;
        cyc("sub_t4", 3'd4, C_EO | C_AI | C_SU);
        alu_carry = 1'b1;
        alu_zero  = 1'b0;

        fetch("jc2", 4'b0111);
        cyc("jc_not_taken", 3'd2, 15'h0000);
        cyc("jc2_t3", 3'd3, 15'h0000);
        cyc("jc2_t4", 3'd4, 15'h0000);
        fetch("jz2", 4'b1000);
        cyc("jz_taken", 3'd2, C_IO | C_J);
        cyc("jz2_t3", 3'd3, 15'h0000);
        cyc("jz2_t4", 3'd4, 15'h0000);

        // Memory and immediate instructions
        fetch("lda", 4'b0001);
        cyc("lda_t2", 3'd2, C_IO | C_MI);
        cyc("lda_t3", 3'd3, C_RO | C_AI);
        cyc("lda_t4", 3'd4, 15'h0000);
        fetch("sta", 4'b0100);
        cyc("sta_t2", 3'd2, C_IO | C_MI);
        cyc("sta_t3", 3'd3, C_AO | C_RI);
        cyc("sta_t4", 3'd4, 15'h0000);
        fetch("ldi", 4'b0101);
        cyc("ldi_t2", 3'd2, C_IO | C_AI);
        cyc("ldi_t3", 3'd3, 15'h0000);
        cyc("ldi_t4", 3'd4, 15'h0000);
        fetch("jmp", 4'b0110);
        cyc("jmp_t2", 3'd2, C_IO | C_J);
        cyc("jmp_t3", 3'd3, 15'h0000);
        cyc("jmp_t4", 3'd4, 15'h0000);
        fetch("out", 4'b1110);
        cyc("out_t2", 3'd2, C_AO | C_OI);
        cyc("out_t3", 3'd3, 15'h0000);
        cyc("out_t4", 3'd4, 15'h0000);
        fetch("undef", 4'b1001);
        cyc("undef_t2", 3'd2, 15'h0000);
        cyc("undef_t3", 3'd3, 15'h0000);
        cyc("undef_t4", 3'd4, 15'h0000);

        // Set both flags, then reset in the middle of an LDA
        fetch("add2", 4'b0010);
        cyc("add2_t2", 3'd2, C_IO | C_MI);
        cyc("add2_t3", 3'd3, C_RO | C_BI);
        alu_carry = 1'b1;
        alu_zero  = 1'b1;
        cyc("add2_t4", 3'd4, C_EO | C_AI);
        fetch("lda2", 4'b0001);
        cyc("lda2_t2", 3'd2, C_IO | C_MI);
        RESETn = 1'b0;
        #1;
        chk("rst_mid_ctrl", 16'(ctrl), 16'h0000);
        chk("rst_mid_step", 16'(step), 16'h0003);
        @(posedge clk);
        #1;
        RESETn = 1'b1;
        fetch("rst_mid", 4'b0111);
        cyc("rst_jc_cleared", 3'd2, 15'h0000);
        cyc("rst_jc_t3", 3'd3, 15'h0000);
        cyc("rst_jc_t4", 3'd4, 15'h0000);
        fetch("rst_jz", 4'b1000);
        cyc("rst_jz_cleared", 3'd2, 15'h0000);
        cyc("rst_jz_t3", 3'd3, 15'h0000);
        cyc("rst_jz_t4", 3'd4, 15'h0000);
`endif

        // HLT: parked at T2 with only HLT asserted until reset
        fetch("hlt", 4'b1111);
        #1;
        chk("hlt_t2_ctrl", 16'(ctrl), 16'(C_HLT));
        chk("hlt_t2_halted", 16'(halted), 16'h0000);
        @(posedge clk);
        #1;
        opcode = 4'b0000;
        for (int i = 0; i < 20; i++) begin
            #1;
            chk("halt_step", 16'(step), 16'h0002);
            chk("halt_ctrl", 16'(ctrl), 16'(C_HLT));
            chk("halt_flag", 16'(halted), 16'h0001);
            @(posedge clk);
            #1;
        end
        RESETn = 1'b0;
        #1;
        chk("halt_rst_ctrl", 16'(ctrl), 16'h0000);
        @(posedge clk);
        #1;
        chk("halt_rst_step", 16'(step), 16'h0000);
        chk("halt_rst_halted", 16'(halted), 16'h0000);
        RESETn = 1'b1;
        cyc("post_halt_t0", 3'd0, W_T0);
        cyc("post_halt_t1", 3'd1, W_T1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
